// File: rtl/riscv_ctrl_pipe.sv
// Control pipeline from decode to writeback: E/M/W stage registers, branch/jump resolution in E.
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.
module riscv_ctrl_pipe #(
  parameter int PERF_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       validD,
  input  logic       regWriteD,
  input  logic [1:0] resultSrcD,
  input  logic       memWriteD,
  input  logic [1:0] jumpD,
  input  logic [2:0] branchD,
  input  logic [2:0] ALUControlD,
  input  logic       ALUSrcD,
  input  logic       luiD,
  input  logic       flushE,
  input  logic       zeroE,
  input  logic       ltE,
  output logic [2:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       luiE,
  output logic       loadE,
  output logic       regWriteE,
  output logic [1:0] pcSrcE,
  output logic       regWriteM,
  output logic [1:0] resultSrcM,
  output logic       memWriteM,
  output logic       regWriteW,
  output logic [1:0] resultSrcW,
  output logic       retireW
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] retiredCnt,
  output logic [PERF_W-1:0] redirectCnt
`endif
);

  logic       validE_q, validE_d;
  logic       regWriteE_q, regWriteE_d;
  logic [1:0] resultSrcE_q, resultSrcE_d;
  logic       memWriteE_q, memWriteE_d;
  logic [1:0] jumpE_q, jumpE_d;
  logic [2:0] branchE_q, branchE_d;
  logic [2:0] ALUControlE_q, ALUControlE_d;
  logic       ALUSrcE_q, ALUSrcE_d;
  logic       luiE_q, luiE_d;

  logic       validM_q, validM_d;
  logic       regWriteM_q, regWriteM_d;
  logic [1:0] resultSrcM_q, resultSrcM_d;
  logic       memWriteM_q, memWriteM_d;

  logic       validW_q, validW_d;
  logic       regWriteW_q, regWriteW_d;
  logic [1:0] resultSrcW_q, resultSrcW_d;

  // A flush or an invalid D slot both load an all-zero bubble into E.
  always_comb begin
    validE_d      = 1'b0;
    regWriteE_d   = 1'b0;
    resultSrcE_d  = 2'b00;
    memWriteE_d   = 1'b0;
    jumpE_d       = 2'b00;
    branchE_d     = 3'b000;
    ALUControlE_d = 3'b000;
    ALUSrcE_d     = 1'b0;
    luiE_d        = 1'b0;
    if (validD && !flushE) begin
      validE_d      = 1'b1;
      regWriteE_d   = regWriteD;
      resultSrcE_d  = resultSrcD;
      memWriteE_d   = memWriteD;
      jumpE_d       = jumpD;
      branchE_d     = branchD;
      ALUControlE_d = ALUControlD;
      ALUSrcE_d     = ALUSrcD;
      luiE_d        = luiD;
    end
  end

  always_comb begin
    validM_d     = validE_q;
    regWriteM_d  = regWriteE_q & validE_q;
    memWriteM_d  = memWriteE_q & validE_q;
    resultSrcM_d = resultSrcE_q;
    validW_d     = validM_q;
    regWriteW_d  = regWriteM_q & validM_q;
    resultSrcW_d = resultSrcM_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      validE_q      <= 1'b0;
      regWriteE_q   <= 1'b0;
      resultSrcE_q  <= 2'b00;
      memWriteE_q   <= 1'b0;
      jumpE_q       <= 2'b00;
      branchE_q     <= 3'b000;
      ALUControlE_q <= 3'b000;
      ALUSrcE_q     <= 1'b0;
      luiE_q        <= 1'b0;
      validM_q      <= 1'b0;
      regWriteM_q   <= 1'b0;
      resultSrcM_q  <= 2'b00;
      memWriteM_q   <= 1'b0;
      validW_q      <= 1'b0;
      regWriteW_q   <= 1'b0;
      resultSrcW_q  <= 2'b00;
    end else begin
      validE_q      <= validE_d;
      regWriteE_q   <= regWriteE_d;
      resultSrcE_q  <= resultSrcE_d;
      memWriteE_q   <= memWriteE_d;
      jumpE_q       <= jumpE_d;
      branchE_q     <= branchE_d;
      ALUControlE_q <= ALUControlE_d;
      ALUSrcE_q     <= ALUSrcE_d;
      luiE_q        <= luiE_d;
      validM_q      <= validM_d;
      regWriteM_q   <= regWriteM_d;
      resultSrcM_q  <= resultSrcM_d;
      memWriteM_q   <= memWriteM_d;
      validW_q      <= validW_d;
      regWriteW_q   <= regWriteW_d;
      resultSrcW_q  <= resultSrcW_d;
    end
  end

  // Jumps take priority over branches; reserved codes and bubbles never redirect.
  always_comb begin
    pcSrcE = 2'b00;
    if (validE_q) begin
      case (jumpE_q)
        2'b01:   pcSrcE = 2'b01;
        2'b10:   pcSrcE = 2'b10;
        default: begin
          case (branchE_q)
            3'b001:  pcSrcE = zeroE  ? 2'b01 : 2'b00;
            3'b010:  pcSrcE = !zeroE ? 2'b01 : 2'b00;
            3'b011:  pcSrcE = ltE    ? 2'b01 : 2'b00;
            3'b100:  pcSrcE = !ltE   ? 2'b01 : 2'b00;
            default: pcSrcE = 2'b00;
          endcase
        end
      endcase
    end
  end

  assign ALUControlE = ALUControlE_q;
  assign ALUSrcE     = ALUSrcE_q;
  assign luiE        = luiE_q;
  assign loadE       = validE_q & (resultSrcE_q == 2'b01);
  assign regWriteE   = regWriteE_q & validE_q;
  assign regWriteM   = regWriteM_q & validM_q;
  assign resultSrcM  = resultSrcM_q;
  assign memWriteM   = memWriteM_q & validM_q;
  assign regWriteW   = regWriteW_q & validW_q;
  assign resultSrcW  = resultSrcW_q;
  assign retireW     = validW_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_W-1:0] retiredCnt_q, retiredCnt_d;
  logic [PERF_W-1:0] redirectCnt_q, redirectCnt_d;

  always_comb begin
    retiredCnt_d  = retiredCnt_q;
    redirectCnt_d = redirectCnt_q;
    if (retireW) retiredCnt_d = retiredCnt_q + PERF_W'(1);
    if (pcSrcE != 2'b00) redirectCnt_d = redirectCnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      retiredCnt_q  <= '0;
      redirectCnt_q <= '0;
    end else begin
      retiredCnt_q  <= retiredCnt_d;
      redirectCnt_q <= redirectCnt_d;
    end
  end

  assign retiredCnt  = retiredCnt_q;
  assign redirectCnt = redirectCnt_q;
`endif

endmodule
